// File: rtl/salsa_block_collector_if.sv
// Byte-in / word-out bus between the Salsa20 hash core, the block
// collector and the downstream word consumer.
interface salsa_block_collector_if;
    logic        clear;
    logic [7:0]  data_in;
    logic        writes;
    logic        ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        block_done;
    logic        overflow;

    // Driver side: hash core plus word consumer (the testbench).
    modport master (
        output clear,
        output data_in,
        output writes,
        output word_ready,
        input  ready,
        input  word_out,
        input  word_valid,
        input  block_done,
        input  overflow
    );

    // Collector side.
    modport slave (
        input  clear,
        input  data_in,
        input  writes,
        input  word_ready,
        output ready,
        output word_out,
        output word_valid,
        output block_done,
        output overflow
    );
endinterface

// File: rtl/salsa_block_collector.sv
// Salsa20 block collector: gathers a byte-serial keystream block into
// little-endian 32-bit words, then hands the words out one at a time on a
// valid/ready handshake. Bytes offered while draining are dropped and
// recorded in a sticky overflow flag. BLOCK_WORDS must be at least 2.
module salsa_block_collector #(
    parameter int BLOCK_WORDS = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    salsa_block_collector_if.slave  bus
);

    localparam int NUM_BYTES = 4 * BLOCK_WORDS;
    localparam int BYTE_W    = $clog2(NUM_BYTES);
    localparam int WORD_W    = BYTE_W - 2;

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
    logic               block_done_q, block_done_d;
    logic               overflow_q, overflow_d;
    logic [31:0]        blk_q [BLOCK_WORDS];
    logic [31:0]        blk_d [BLOCK_WORDS];

    logic [WORD_W-1:0]  fill_word;
    logic [1:0]         fill_lane;

    // Byte k goes to word k/4, byte lane k%4 (Salsa20 little-endian order).
    assign fill_word = byte_cnt_q[BYTE_W-1:2];
    assign fill_lane = byte_cnt_q[1:0];

    assign bus.ready      = (state_q == FILL);
    assign bus.word_valid = (state_q == DRAIN);
    assign bus.word_out   = (state_q == DRAIN) ? blk_q[word_cnt_q] : 32'h0;
    assign bus.block_done = block_done_q;
    assign bus.overflow   = overflow_q;

    // Next-state logic: clear overrides everything, then fill or drain.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        block_done_d = 1'b0;
        overflow_d   = overflow_q;
        blk_d        = blk_q;

        if (bus.clear) begin
            state_d    = FILL;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (bus.writes && (state_q != FILL)) begin
                overflow_d = 1'b1;
            end

            case (state_q)
                FILL: begin
                    if (bus.writes) begin
                        blk_d[fill_word][{fill_lane, 3'b000} +: 8] = bus.data_in;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = DRAIN;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.word_ready) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_d   = '0;
                            state_d      = FILL;
                            block_done_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q + WORD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            block_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            block_done_q <= block_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Block storage needs no reset: word_out is masked outside DRAIN.
    always_ff @(posedge clk) begin
        blk_q <= blk_d;
    end

endmodule

// File: tb/tb_salsa_block_collector.sv
// Testbench for salsa_block_collector: a table of whole-block runs plus
// hand-written clear, back-to-back and reset-abort sequences. Expected
// words are queued when a block's bytes are driven and popped by a
// monitor whenever the DUT hands a word over.
module tb_salsa_block_collector;

    localparam int BW = 16;
    localparam int NB = 4 * BW;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    salsa_block_collector_if bus ();

    salsa_block_collector #(.BLOCK_WORDS(BW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          total    = 0;
    int          bad      = 0;
    int          acc_cnt  = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = 32'h0;

    typedef struct {
        logic [7:0]  base;
        bit          toggle;
        bit          inject;
        int          exp_cycles;
        logic        exp_ovf;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs [4];

    // Compare one value and report it on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drive all inputs for one cycle, then return just after the edge.
    task automatic applyStimulus(input logic [7:0] d, input logic w,
                                 input logic wr, input logic clr);
        bus.data_in    = d;
        bus.writes     = w;
        bus.word_ready = wr;
        bus.clear      = clr;
        @(posedge clk);
        #1;
    endtask

    // Queue the words a block starting at byte value base must produce.
    task automatic pushBlock(input logic [7:0] base);
        logic [7:0] b;
        for (int i = 0; i < BW; i++) begin
            b = base + 8'(4 * i);
            exp_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
        end
    endtask

    // Send n incrementing bytes, one per cycle.
    task automatic sendBytes(input logic [7:0] base, input int n, input logic wr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(base + 8'(i), 1'b1, wr, 1'b0);
        end
    endtask

    // Send a full expected block, checking the FILL outputs half way.
    task automatic sendBlock(input logic [7:0] base);
        pushBlock(base);
        sendBytes(base, NB / 2, 1'b1);
        checkOutput("fill_ready", 32'(bus.ready), 32'd1);
        checkOutput("fill_valid", 32'(bus.word_valid), 32'd0);
        sendBytes(base + 8'(NB / 2), NB / 2, 1'b1);
    endtask

    // Run cycles until block_done is seen; optionally stall and push 0xAA.
    task automatic drainBlock(input bit toggle, input bit inject, output int cycles);
        bit   seen;
        logic wr;
        seen   = 1'b0;
        cycles = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            wr = toggle ? logic'((c % 2) == 0) : 1'b1;
            applyStimulus(inject ? 8'hAA : 8'h00, inject, wr, 1'b0);
            cycles++;
            if (bus.block_done) seen = 1'b1;
        end
        if (!seen) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: pops on each handshake, checks stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.word_valid) begin
                checkOutput("stall_stable", bus.word_out, prev_word);
            end
            if (bus.word_valid && bus.word_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    checkOutput("word", bus.word_out, exp_q.pop_front());
                end
            end
            if (bus.block_done) begin
                done_cnt++;
                checkOutput("done_ready", 32'(bus.ready), 32'd1);
            end
            prev_stall = bus.word_valid && !bus.word_ready;
            prev_word  = bus.word_out;
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        int cyc;
        int acc0;
        int done0;

        vecs[0] = '{8'h00, 1'b0, 1'b0, 16, 1'b0, 32'h03020100};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 31, 1'b0, 32'h03020100};
        vecs[2] = '{8'h20, 1'b0, 1'b1, 16, 1'b1, 32'h23222120};
        vecs[3] = '{8'h80, 1'b1, 1'b0, 31, 1'b1, 32'h83828180};

        reset_n        = 1'b0;
        bus.clear      = 1'b0;
        bus.writes     = 1'b0;
        bus.data_in    = 8'h00;
        bus.word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_valid", 32'(bus.word_valid), 32'd0);
        checkOutput("rst_done", 32'(bus.block_done), 32'd0);
        checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("rst_word", bus.word_out, 32'd0);
        reset_n = 1'b1;

        // Table-driven whole blocks.
        for (int r = 0; r < 4; r++) begin
            acc0  = acc_cnt;
            done0 = done_cnt;
            sendBlock(vecs[r].base);
            checkOutput("first_valid", 32'(bus.word_valid), 32'd1);
            checkOutput("first_word", bus.word_out, vecs[r].exp_first);
            drainBlock(vecs[r].toggle, vecs[r].inject, cyc);
            bus.writes     = 1'b0;
            bus.word_ready = 1'b0;
            checkOutput("done_cycle_ready", 32'(bus.ready), 32'd1);
            @(negedge clk);
            #1;
            checkOutput("drain_cycles", 32'(cyc), 32'(vecs[r].exp_cycles));
            checkOutput("block_accepts", 32'(acc_cnt - acc0), 32'd16);
            checkOutput("block_done_pulses", 32'(done_cnt - done0), 32'd1);
            checkOutput("overflow", 32'(bus.overflow), 32'(vecs[r].exp_ovf));
            checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Clear together with a write after 10 bytes.
        $display("[TB] clear sequence");
        sendBytes(8'h00, 10, 1'b1);
        applyStimulus(8'h99, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("clr_ready", 32'(bus.ready), 32'd1);
        checkOutput("clr_valid", 32'(bus.word_valid), 32'd0);
        checkOutput("clr_done", 32'(bus.block_done), 32'd0);
        sendBlock(8'hC0);
        checkOutput("clr_first_word", bus.word_out, 32'hC3C2C1C0);
        drainBlock(1'b0, 1'b0, cyc);
        bus.writes = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("clr_ovf_after", 32'(bus.overflow), 32'd0);
        checkOutput("clr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back blocks with writes held high throughout.
        $display("[TB] back-to-back sequence");
        sendBlock(8'h10);
        drainBlock(1'b0, 1'b1, cyc);
        checkOutput("b2b_done", 32'(bus.block_done), 32'd1);
        checkOutput("b2b_ready", 32'(bus.ready), 32'd1);
        sendBlock(8'h50);
        checkOutput("b2b_first_word", bus.word_out, 32'h53525150);
        drainBlock(1'b0, 1'b0, cyc);
        bus.writes = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("b2b_ovf", 32'(bus.overflow), 32'd1);
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-FILL after 30 bytes.
        $display("[TB] reset-abort sequence");
        sendBytes(8'h00, 30, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("abort_rst_valid", 32'(bus.word_valid), 32'd0);
        checkOutput("abort_rst_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("abort_rst_word", bus.word_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset mid-DRAIN with the consumer stalled.
        sendBytes(8'h00, NB, 1'b0);
        checkOutput("abort_drain_valid", 32'(bus.word_valid), 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_drain_rst_valid", 32'(bus.word_valid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        sendBlock(8'h40);
        checkOutput("post_rst_first_word", bus.word_out, 32'h43424140);
        drainBlock(1'b0, 1'b0, cyc);
        bus.writes = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("total_accepts", 32'(acc_cnt), 32'(8 * BW));
        checkOutput("total_done", 32'(done_cnt), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/salsa_block_collector.md
SALSA_BLOCK_COLLECTOR -- requirements
Module: salsa_block_collector

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 16, giving the number of 32-bit words per block (64 bytes at default).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous abort: discard partial block, return to FILL.
REQ-005 SHALL have port data_in  input  8  keystream/hash byte from the byte-serial Salsa20 hash core.
REQ-006 SHALL have port writes  input  1  byte strobe; data_in valid this cycle.
REQ-007 SHALL have port ready  output  1  high while in FILL (bytes accepted).
REQ-008 SHALL have port word_out  output  32  current output word.
REQ-009 SHALL have port word_valid  output  1  word_out holds a valid word.
REQ-010 SHALL have port word_ready  input  1  downstream accepts word_out.
REQ-011 SHALL have port block_done  output  1  one-cycle pulse after the last word of a block is accepted.
REQ-012 SHALL have port overflow  output  1  sticky flag: a byte was offered while not ready.

Function
REQ-013 SHALL implement two states, FILL and DRAIN; reset state FILL.
REQ-014 In FILL, each cycle with writes=1 SHALL store data_in and increment the byte counter (width clog2(4*BLOCK_WORDS)).
REQ-015 Byte k of a block SHALL land in word k/4, bits [8*(k%4)+7 : 8*(k%4)] (little-endian, Salsa20 word order).
REQ-016 The write of byte 4*BLOCK_WORDS-1 SHALL move FILL->DRAIN; word_valid SHALL be 1 on the next cycle with word 0 on word_out; the byte counter SHALL wrap to 0.
REQ-017 In DRAIN, word_valid SHALL stay 1 and word_out stable until word_valid&&word_ready at a rising edge; the word index then increments.
REQ-018 Acceptance of word BLOCK_WORDS-1 SHALL move DRAIN->FILL; block_done SHALL be 1 for exactly the following cycle, and ready SHALL be 1 in that same cycle.
REQ-019 word_valid SHALL be 0 in FILL; word_out is don't-care when word_valid=0.
REQ-020 writes=1 while ready=0 (DRAIN, including the cycle of the final word handshake) SHALL drop the byte and set overflow.
REQ-021 overflow SHALL remain 1 until reset_n low or clear=1.
REQ-022 clear=1 SHALL take priority over writes and word handshakes: next state FILL, counters 0, overflow 0, block_done 0, stored buffer contents don't-care.
REQ-023 Every byte with writes=1 in FILL SHALL be accepted with zero wait cycles; there SHALL be no backpressure on bytes in FILL.
REQ-024 Throughput SHALL be one byte per cycle in FILL and one word per cycle in DRAIN when word_ready is held 1.

Reset
REQ-025 While reset_n=0: state FILL, byte and word counters 0, ready=1, word_valid=0, block_done=0, overflow=0, word_out=0.
REQ-026 Deassertion of reset_n SHALL allow a byte write on the first rising edge after deassertion.
REQ-027 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the block without emitting further words.

Verification
REQ-028 Bytes 0x00..0x3F on 64 consecutive cycles, word_ready=1 -> words 0x03020100, 0x07060504, ..., 0x3F3E3D3C on 16 consecutive cycles; block_done pulses once; overflow=0.
REQ-029 Same stimulus, word_ready toggling 1/0 each cycle -> identical word sequence; word_out stable while word_valid=1 and word_ready=0; 16 accepts total.
REQ-030 writes=1 with data 0xAA during DRAIN -> byte dropped, overflow=1 and stays 1; next block's word 0 is unaffected by 0xAA.
REQ-031 reset_n pulled low after 30 bytes, then 64 fresh bytes 0x40..0x7F -> first word 0x43424140; no words from the aborted block.
REQ-032 clear=1 in the same cycle as writes=1 after 10 bytes -> byte not stored, counter 0, overflow 0; next 64 bytes form a correct block.
REQ-033 Two back-to-back blocks with writes held 1 through the block_done cycle -> the byte in the block_done cycle is byte 0 of block 2; every byte during DRAIN sets overflow.
